// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decode with a valid/ready handshake.
// Single-cycle ops reach the output on the edge that accepts them. M-extension
// ops hold back-pressure until their MUL/DIV latency has elapsed.
module alu_ctrl_seq #(
  parameter int unsigned CTRL_W   = 5,
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned DIV_LAT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALUOp,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              illegal,
  output logic              mdu_start,
  output logic              mdu_abort
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam int unsigned CODE_W  = 5;

  localparam logic [CODE_W-1:0] C_ADD  = 5'd0;
  localparam logic [CODE_W-1:0] C_SUB  = 5'd1;
  localparam logic [CODE_W-1:0] C_AND  = 5'd2;
  localparam logic [CODE_W-1:0] C_OR   = 5'd3;
  localparam logic [CODE_W-1:0] C_XOR  = 5'd4;
  localparam logic [CODE_W-1:0] C_SLT  = 5'd5;
  localparam logic [CODE_W-1:0] C_SLL  = 5'd6;
  localparam logic [CODE_W-1:0] C_SRL  = 5'd7;
  localparam logic [CODE_W-1:0] C_SRA  = 5'd8;
  localparam logic [CODE_W-1:0] C_SLTU = 5'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;

  logic [CODE_W-1:0] dec_code;
  logic              dec_illegal;
  logic              dec_m;
  logic [CNT_W-1:0]  dec_lat_m1;
  logic              m_sel;
  logic              f7_base;
  logic              accept;

  // Only op[5] distinguishes R-type from I-type; the rest of the opcode is decoded upstream.
  logic unused_op;
  assign unused_op = ^{op[6], op[4:0]};

  assign m_sel   = ENABLE_M && op[5] && (funct7 == 7'b0000001);
  assign f7_base = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

  // Combinational decode of the incoming fields into an operation code.
  always_comb begin
    dec_code    = C_ADD;
    dec_illegal = 1'b0;
    dec_m       = 1'b0;
    case (ALUOp)
      2'b00: dec_code = C_ADD;
      2'b01: begin
        case (funct3)
          3'b000, 3'b001: dec_code = C_SUB;
          3'b100, 3'b101: dec_code = C_SLT;
          3'b110, 3'b111: dec_code = C_SLTU;
          default: begin
            dec_code    = C_SUB;
            dec_illegal = 1'b1;
          end
        endcase
      end
      2'b10: begin
        if (m_sel) begin
          dec_code = {2'b10, funct3};
          dec_m    = 1'b1;
        end else if (op[5] && !f7_base) begin
          dec_code    = C_ADD;
          dec_illegal = 1'b1;
        end else begin
          case (funct3)
            3'b000:  dec_code = (op[5] && funct7[5]) ? C_SUB : C_ADD;
            3'b001:  dec_code = C_SLL;
            3'b010:  dec_code = C_SLT;
            3'b011:  dec_code = C_SLTU;
            3'b100:  dec_code = C_XOR;
            3'b101:  dec_code = funct7[5] ? C_SRA : C_SRL;
            3'b110:  dec_code = C_OR;
            default: dec_code = C_AND;
          endcase
        end
      end
      default: begin
        dec_code    = C_ADD;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Remaining WAIT cycles after accept: DIV group has funct3[2] set.
  assign dec_lat_m1 = funct3[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

  // Flush blocks acceptance in the same cycle it kills the pending op.
  assign in_ready = !flush && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  // Sequencer: state, latency counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      ALUControl <= '0;
      illegal    <= 1'b0;
      mdu_start  <= 1'b0;
      mdu_abort  <= 1'b0;
    end else begin
      mdu_start <= 1'b0;
      mdu_abort <= 1'b0;
      if (flush) begin
        state     <= IDLE;
        cnt       <= '0;
        out_valid <= 1'b0;
        mdu_abort <= (state == WAIT);
      end else if (accept) begin
        ALUControl <= CTRL_W'(dec_code);
        illegal    <= dec_illegal;
        mdu_start  <= dec_m;
        if (dec_m && (dec_lat_m1 != '0)) begin
          state     <= WAIT;
          cnt       <= dec_lat_m1;
          out_valid <= 1'b0;
        end else begin
          state     <= HOLD;
          cnt       <= '0;
          out_valid <= 1'b1;
        end
      end else begin
        case (state)
          HOLD: begin
            if (out_ready) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
          WAIT: begin
            if (cnt == CNT_W'(1)) begin
              state     <= HOLD;
              cnt       <= '0;
              out_valid <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Testbench for alu_ctrl_seq: decode table, directed multi-cycle sequences and
// randomized transactions checked against a rule-level reference model.
module tb_alu_ctrl_seq;

  localparam int unsigned CTRL_W  = 5;
  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned DIV_LAT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_valid_nm = 1'b0;
  logic [1:0]        ALUOp = '0;
  logic [6:0]        op = '0;
  logic [2:0]        funct3 = '0;
  logic [6:0]        funct7 = '0;
  logic              flush = 1'b0;
  logic              out_ready = 1'b0;

  logic              in_ready, out_valid, illegal, mdu_start, mdu_abort;
  logic [CTRL_W-1:0] ALUControl;
  logic              in_ready_nm, out_valid_nm, illegal_nm, mdu_start_nm, mdu_abort_nm;
  logic [CTRL_W-1:0] ALUControl_nm;

  int n_pass  = 0;
  int n_total = 0;

  alu_ctrl_seq #(.CTRL_W(CTRL_W), .ENABLE_M(1'b1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .op(op), .funct3(funct3), .funct7(funct7), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .ALUControl(ALUControl),
    .illegal(illegal), .mdu_start(mdu_start), .mdu_abort(mdu_abort)
  );

  alu_ctrl_seq #(.CTRL_W(CTRL_W), .ENABLE_M(1'b0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_dut_nm (
    .clk(clk), .rst(rst), .in_valid(in_valid_nm), .in_ready(in_ready_nm),
    .ALUOp(ALUOp), .op(op), .funct3(funct3), .funct7(funct7), .flush(flush),
    .out_valid(out_valid_nm), .out_ready(out_ready), .ALUControl(ALUControl_nm),
    .illegal(illegal_nm), .mdu_start(mdu_start_nm), .mdu_abort(mdu_abort_nm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] a, input logic [6:0] o, input logic [2:0] f3,
                        input logic [6:0] f7);
    ALUOp = a; op = o; funct3 = f3; funct7 = f7;
  endtask

  // Reference model: expected code, illegal flag and accept-to-valid latency.
  function automatic void model(input logic [1:0] a, input logic [6:0] o, input logic [2:0] f3,
                                input logic [6:0] f7, input bit en_m,
                                output int code, output int ill, output int lat);
    int br[8];
    int base[8];
    bit rtype;
    br   = '{1, 1, 1, 1, 5, 5, 9, 9};
    base = '{0, 6, 5, 9, 4, 7, 3, 2};
    code = 0; ill = 0; lat = 1;
    rtype = o[5];
    if (a == 2'd0) begin
      code = 0;
    end else if (a == 2'd1) begin
      code = br[f3];
      ill  = (f3 == 3'd2 || f3 == 3'd3) ? 1 : 0;
    end else if (a == 2'd2) begin
      if (rtype && f7 == 7'd1 && en_m) begin
        code = 16 + int'(f3);
        lat  = (f3 >= 3'd4) ? int'(DIV_LAT) : int'(MUL_LAT);
      end else if (rtype && !(f7 == 7'd0 || f7 == 7'd32)) begin
        code = 0; ill = 1;
      end else begin
        code = base[f3];
        if (f3 == 3'd0 && rtype && f7[5]) code = 1;
        if (f3 == 3'd5 && f7[5]) code = 8;
      end
    end else begin
      code = 0; ill = 1;
    end
  endfunction

  typedef struct {
    logic [1:0] aluop;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    int         code;
    int         ill;
  } vec_t;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_L = 7'b0000011;

  vec_t tbl[21];

  initial begin
    int code, ill, lat, c, k;
    logic [CTRL_W-1:0] held;

    tbl[0]  = '{2'b00, OP_L, 3'b010, 7'h00, 0, 0};
    tbl[1]  = '{2'b01, OP_B, 3'b000, 7'h00, 1, 0};
    tbl[2]  = '{2'b01, OP_B, 3'b001, 7'h00, 1, 0};
    tbl[3]  = '{2'b01, OP_B, 3'b100, 7'h00, 5, 0};
    tbl[4]  = '{2'b01, OP_B, 3'b111, 7'h00, 9, 0};
    tbl[5]  = '{2'b01, OP_B, 3'b010, 7'h00, 1, 1};
    tbl[6]  = '{2'b10, OP_R, 3'b000, 7'h20, 1, 0};
    tbl[7]  = '{2'b10, OP_R, 3'b000, 7'h00, 0, 0};
    tbl[8]  = '{2'b10, OP_I, 3'b000, 7'h20, 0, 0};
    tbl[9]  = '{2'b10, OP_R, 3'b001, 7'h00, 6, 0};
    tbl[10] = '{2'b10, OP_R, 3'b010, 7'h00, 5, 0};
    tbl[11] = '{2'b10, OP_R, 3'b011, 7'h00, 9, 0};
    tbl[12] = '{2'b10, OP_R, 3'b100, 7'h00, 4, 0};
    tbl[13] = '{2'b10, OP_R, 3'b101, 7'h00, 7, 0};
    tbl[14] = '{2'b10, OP_R, 3'b101, 7'h20, 8, 0};
    tbl[15] = '{2'b10, OP_R, 3'b110, 7'h00, 3, 0};
    tbl[16] = '{2'b10, OP_R, 3'b111, 7'h00, 2, 0};
    tbl[17] = '{2'b10, OP_I, 3'b110, 7'h0A, 3, 0};
    tbl[18] = '{2'b10, OP_R, 3'b000, 7'h08, 0, 1};
    tbl[19] = '{2'b11, OP_R, 3'b000, 7'h00, 0, 1};
    tbl[20] = '{2'b10, OP_I, 3'b101, 7'h20, 8, 0};

    // Reset values
    #2 rst = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_code", int'(ALUControl), 0);
    chk("rst_illegal", int'(illegal), 0);
    chk("rst_mdu_start", int'(mdu_start), 0);
    chk("rst_mdu_abort", int'(mdu_abort), 0);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);

    // First op: SUB
    set_op(2'b10, OP_R, 3'b000, 7'h20);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("first_valid", int'(out_valid), 1);
    chk("first_code", int'(ALUControl), 1);
    chk("first_illegal", int'(illegal), 0);

    // Decode table streamed back-to-back with out_ready=1
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      set_op(tbl[i].aluop, tbl[i].opc, tbl[i].f3, tbl[i].f7);
      in_valid = 1'b1;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), int'(in_ready), 1);
      tick();
      chk($sformatf("tbl%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("tbl%0d_code", i), int'(ALUControl), tbl[i].code);
      chk($sformatf("tbl%0d_illegal", i), int'(illegal), tbl[i].ill);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_idle", int'(out_valid), 0);

    // MUL with latency 3
    set_op(2'b10, OP_R, 3'b000, 7'h01);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mul_start", int'(mdu_start), 1);
    chk("mul_w1_valid", int'(out_valid), 0);
    chk("mul_w1_ready", int'(in_ready), 0);
    tick();
    chk("mul_start_pulse", int'(mdu_start), 0);
    chk("mul_w2_valid", int'(out_valid), 0);
    chk("mul_w2_ready", int'(in_ready), 0);
    tick();
    chk("mul_valid", int'(out_valid), 1);
    chk("mul_code", int'(ALUControl), 16);
    tick();
    chk("mul_done_idle", int'(out_valid), 0);

    // DIVU flushed in the 4th WAIT cycle
    set_op(2'b10, OP_R, 3'b101, 7'h01);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("divu_start", int'(mdu_start), 1);
    tick(); tick(); tick();
    flush = 1'b1;
    #1;
    chk("flush_in_ready", int'(in_ready), 0);
    tick();
    flush = 1'b0;
    #1;
    chk("divu_abort", int'(mdu_abort), 1);
    chk("divu_no_valid", int'(out_valid), 0);
    chk("divu_in_ready", int'(in_ready), 1);
    tick();
    chk("divu_abort_pulse", int'(mdu_abort), 0);
    c = 0;
    repeat (8) begin tick(); if (out_valid) c++; end
    chk("divu_never_valid", c, 0);

    // ORI held with out_ready=0 while a new op waits
    set_op(2'b10, OP_I, 3'b110, 7'h00);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    set_op(2'b00, OP_L, 3'b000, 7'h00);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("stall%0d_code", i), int'(ALUControl), 3);
      chk($sformatf("stall%0d_in_ready", i), int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("unstall_code", int'(ALUControl), 0);

    // flush together with out_ready in HOLD
    in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("hold_flush_in_ready", int'(in_ready), 0);
    tick();
    in_valid = 1'b0; flush = 1'b0;
    #1;
    chk("hold_flush_valid", int'(out_valid), 0);
    chk("hold_flush_abort", int'(mdu_abort), 0);
    chk("hold_flush_in_ready2", int'(in_ready), 1);

    // ENABLE_M=0: M encoding and ALUOp=11 both illegal ADD
    set_op(2'b10, OP_R, 3'b000, 7'h01);
    in_valid_nm = 1'b1;
    tick();
    chk("nm_m_valid", int'(out_valid_nm), 1);
    chk("nm_m_illegal", int'(illegal_nm), 1);
    chk("nm_m_code", int'(ALUControl_nm), 0);
    chk("nm_m_start", int'(mdu_start_nm), 0);
    set_op(2'b11, OP_R, 3'b111, 7'h00);
    tick();
    in_valid_nm = 1'b0;
    chk("nm_op11_illegal", int'(illegal_nm), 1);
    chk("nm_op11_code", int'(ALUControl_nm), 0);

    // Reset during WAIT: no abort pulse
    set_op(2'b10, OP_R, 3'b100, 7'h01);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_abort", int'(mdu_abort), 0);
    chk("midrst_start", int'(mdu_start), 0);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    tick();
    chk("midrst_abort2", int'(mdu_abort), 0);
    chk("midrst_valid2", int'(out_valid), 0);

    // Randomized transactions against the reference model
    out_ready = 1'b1;
    for (int t = 0; t < 200; t++) begin
      logic [1:0] a;
      logic [6:0] o, f7;
      logic [2:0] f3;
      a  = 2'($urandom_range(0, 3));
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       o = OP_R;
        1:       o = OP_I;
        default: o = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      model(a, o, f3, f7, 1'b1, code, ill, lat);
      set_op(a, o, f3, f7);
      in_valid = 1'b1;
      #1;
      chk($sformatf("rnd%0d_in_ready", t), int'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("rnd%0d_start", t), int'(mdu_start), (lat > 1 || (a == 2'd2 && o[5] && f7 == 7'd1)) ? 1 : 0);
      c = 1;
      while (!out_valid && c < 30) begin
        chk($sformatf("rnd%0d_wait_ready", t), int'(in_ready), 0);
        tick();
        c++;
      end
      chk($sformatf("rnd%0d_latency", t), c, lat);
      chk($sformatf("rnd%0d_code", t), int'(ALUControl), code);
      chk($sformatf("rnd%0d_illegal", t), int'(illegal), ill);
      held = ALUControl;
      k = $urandom_range(0, 2);
      if (k > 0) begin
        out_ready = 1'b0;
        repeat (k) begin
          tick();
          chk($sformatf("rnd%0d_stall_valid", t), int'(out_valid), 1);
          chk($sformatf("rnd%0d_stall_code", t), int'(ALUControl), int'(held));
        end
        out_ready = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
